// File: rtl/rx_ctrl_pkg.sv
// rtl/rx_ctrl_pkg.sv - shared types and helpers for the receive frame controller
package rx_ctrl_pkg;

   typedef enum logic [2:0] {
      HUNT    = 3'd0,
      LEN     = 3'd1,
      PAYLOAD = 3'd2,
      CHK     = 3'd3,
      STATUS  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_CSUM    = 2'd1,
      ERR_TIMEOUT = 2'd2,
      ERR_LEN     = 2'd3
   } err_t;

   // Byte idx of the sync word, idx 0 being the first byte on the wire (MSB).
   function automatic logic [7:0] sync_byte(input logic [31:0] word, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/rx_sync_hunter.sv
// rtl/rx_sync_hunter.sv - sync word tracker with single-byte overlap recovery
module rx_sync_hunter
   import rx_ctrl_pkg::*;
#(
   parameter logic [31:0] SYNC_WORD = 32'habcdefab
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data,
   input  logic       strobe,
   input  logic       clear,
   output logic       sync_found
);

   logic [1:0] idx;
   logic [1:0] idx_next;

   // Next sync index; a mismatching byte that is itself the first sync byte restarts at index 1.
   always_comb begin
      idx_next   = idx;
      sync_found = 1'b0;
      if (clear) begin
         idx_next = 2'd0;
      end else if (strobe) begin
         if (data == sync_byte(SYNC_WORD, idx)) begin
            if (idx == 2'd3) begin
               idx_next   = 2'd0;
               sync_found = 1'b1;
            end else begin
               idx_next = idx + 2'd1;
            end
         end else if (data == sync_byte(SYNC_WORD, 2'd0)) begin
            idx_next = 2'd1;
         end else begin
            idx_next = 2'd0;
         end
      end
   end

   // Sync index register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= 2'd0;
      end else begin
         idx <= idx_next;
      end
   end

endmodule

// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - frame controller: sync hunt, length, payload stream, checksum, status
module rx_frame_ctrl
   import rx_ctrl_pkg::*;
#(
   parameter logic [31:0] SYNC_WORD = 32'habcdefab,
   parameter int          MAX_WORDS = 255,
   parameter int          TIMEOUT   = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] pay_data,
   output logic       pay_valid,
   output logic       stat_valid,
   input  logic       stat_ready,
   output logic [7:0] frame_len,
   output logic [1:0] err_code,
   output logic       busy
);

   localparam int IW = $clog2(TIMEOUT + 1);

   state_t        state, state_next;
   err_t          err_q, err_next;
   logic [7:0]    len_q, len_next;
   logic [7:0]    acc, acc_next;
   logic [9:0]    cnt, cnt_next;
   logic [9:0]    target;
   logic [IW-1:0] idle, idle_next;
   logic [7:0]    pay_data_next;
   logic          pay_valid_next;
   logic          accept;
   logic          sync_found;
   logic          hunt_strobe;
   logic          hunt_clear;

   // While disabled the source is drained; otherwise only a pending status stalls it.
   assign in_ready    = !en || (state != STATUS);
   assign accept      = in_valid && in_ready;
   assign stat_valid  = (state == STATUS);
   assign busy        = (state != HUNT);
   assign frame_len   = len_q;
   assign err_code    = err_q;
   assign target      = {len_q, 2'b00};

   assign hunt_strobe = accept && en && (state == HUNT);
   assign hunt_clear  = !en || (state != HUNT);

   rx_sync_hunter #(
      .SYNC_WORD (SYNC_WORD)
   ) u_hunter (
      .clk        (clk),
      .rst_n      (rst_n),
      .data       (in_data),
      .strobe     (hunt_strobe),
      .clear      (hunt_clear),
      .sync_found (sync_found)
   );

   // Next-state and datapath: en low dominates, an accepted byte beats the idle timeout.
   always_comb begin
      state_next     = state;
      err_next       = err_q;
      len_next       = len_q;
      acc_next       = acc;
      cnt_next       = cnt;
      idle_next      = idle;
      pay_data_next  = pay_data;
      pay_valid_next = 1'b0;

      if (!en) begin
         state_next = HUNT;
         acc_next   = 8'd0;
         cnt_next   = 10'd0;
         idle_next  = '0;
      end else begin
         case (state)
            HUNT: begin
               if (sync_found) begin
                  state_next = LEN;
                  idle_next  = '0;
               end
            end

            LEN, PAYLOAD, CHK: begin
               if (accept) begin
                  idle_next = '0;
                  if (state == LEN) begin
                     len_next = in_data;
                     acc_next = in_data;
                     cnt_next = 10'd0;
                     if ((in_data == 8'd0) || (32'(in_data) > MAX_WORDS)) begin
                        state_next = STATUS;
                        err_next   = ERR_LEN;
                     end else begin
                        state_next = PAYLOAD;
                     end
                  end else if (state == PAYLOAD) begin
                     acc_next       = acc ^ in_data;
                     cnt_next       = cnt + 10'd1;
                     pay_data_next  = in_data;
                     pay_valid_next = 1'b1;
                     if (cnt == target - 10'd1) begin
                        state_next = CHK;
                     end
                  end else begin
                     err_next   = (in_data == acc) ? ERR_NONE : ERR_CSUM;
                     state_next = STATUS;
                  end
               end else if (idle == IW'(TIMEOUT - 1)) begin
                  state_next = STATUS;
                  err_next   = ERR_TIMEOUT;
               end else begin
                  idle_next = idle + 1'b1;
               end
            end

            STATUS: begin
               if (stat_ready) begin
                  state_next = HUNT;
                  acc_next   = 8'd0;
                  cnt_next   = 10'd0;
                  idle_next  = '0;
               end
            end

            default: begin
               state_next = HUNT;
            end
         endcase
      end
   end

   // State, counters, checksum and registered payload output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= HUNT;
         err_q     <= ERR_NONE;
         len_q     <= 8'd0;
         acc       <= 8'd0;
         cnt       <= 10'd0;
         idle      <= '0;
         pay_data  <= 8'd0;
         pay_valid <= 1'b0;
      end else begin
         state     <= state_next;
         err_q     <= err_next;
         len_q     <= len_next;
         acc       <= acc_next;
         cnt       <= cnt_next;
         idle      <= idle_next;
         pay_data  <= pay_data_next;
         pay_valid <= pay_valid_next;
      end
   end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb/tb_rx_frame_ctrl.sv - self-checking bench for rx_frame_ctrl
module tb_rx_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] in_data;
   logic       in_valid;
   logic       stat_ready;

   logic       in_ready, pay_valid, stat_valid, busy;
   logic [7:0] pay_data, frame_len;
   logic [1:0] err_code;

   logic       in_ready4, pay_valid4, stat_valid4, busy4;
   logic [7:0] pay_data4, frame_len4;
   logic [1:0] err_code4;

   int tests = 0;
   int fails = 0;

   logic [7:0] pay_q[$];
   logic [7:0] st_len_q[$];
   logic [1:0] st_err_q[$];
   bit         rnd_ready = 1'b0;

   typedef struct {
      logic [127:0] data;
      int           nb;
      int           pay_start;
      int           npay;
      logic [7:0]   len;
      logic [1:0]   err;
   } vec_t;

   vec_t tbl[4];

   rx_frame_ctrl u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .pay_data   (pay_data),
      .pay_valid  (pay_valid),
      .stat_valid (stat_valid),
      .stat_ready (stat_ready),
      .frame_len  (frame_len),
      .err_code   (err_code),
      .busy       (busy)
   );

   rx_frame_ctrl #(.MAX_WORDS(4)) u_dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready4),
      .pay_data   (pay_data4),
      .pay_valid  (pay_valid4),
      .stat_valid (stat_valid4),
      .stat_ready (stat_ready),
      .frame_len  (frame_len4),
      .err_code   (err_code4),
      .busy       (busy4)
   );

   always #5 clk = ~clk;

   // Observe payload bytes and completed status transfers mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (pay_valid) pay_q.push_back(pay_data);
         if (stat_valid && stat_ready) begin
            st_len_q.push_back(frame_len);
            st_err_q.push_back(err_code);
         end
      end
   end

   // Random status back-pressure during the randomized phase.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_ready) stat_ready = ($urandom_range(0, 2) != 0);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      in_data  = b;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) begin
         tests++;
         fails++;
         $display("FAIL send_byte timeout: in_ready stuck at 0 for byte %0h", b);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_seq(input logic [127:0] d, input int nb);
      for (int i = 0; i < nb; i++) send_byte(d[8*(nb-1-i) +: 8]);
   endtask

   task automatic run_vec(input int t);
      vec_t       v;
      logic [7:0] bt;
      v = tbl[t];
      pay_q.delete();
      for (int i = 0; i < v.nb; i++) begin
         bt = v.data[8*(v.nb-1-i) +: 8];
         send_byte(bt);
         if (i >= v.pay_start && i < v.pay_start + v.npay) begin
            check($sformatf("vec%0d pay_valid byte%0d", t, i), pay_valid, 1);
            check($sformatf("vec%0d pay_data byte%0d", t, i), pay_data, bt);
         end
      end
      check($sformatf("vec%0d stat_valid", t), stat_valid, 1);
      check($sformatf("vec%0d frame_len", t), frame_len, v.len);
      check($sformatf("vec%0d err_code", t), err_code, v.err);
      check($sformatf("vec%0d payload count", t), pay_q.size(), v.npay);
      step();
      check($sformatf("vec%0d stat_valid pulse end", t), stat_valid, 0);
   endtask

   initial begin
      logic [7:0] fb[$];
      logic [7:0] ep[$];
      logic [7:0] bt, n, acc, csum;
      logic [1:0] ee;
      int         g;

      tbl[0] = '{128'hABCDEFAB011122334445, 10, 5, 4, 8'h01, 2'd0};
      tbl[1] = '{128'hABCDEFAB011122334400, 10, 5, 4, 8'h01, 2'd1};
      tbl[2] = '{128'hABABCDEFAB0201020304050607080A, 15, 6, 8, 8'h02, 2'd0};
      tbl[3] = '{128'hABCDEFAB00, 5, 5, 0, 8'h00, 2'd3};

      rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_data = 8'h00; stat_ready = 1'b1;
      repeat (3) step();
      check("reset in_ready", in_ready, 1);
      check("reset pay_data", pay_data, 0);
      check("reset pay_valid", pay_valid, 0);
      check("reset stat_valid", stat_valid, 0);
      check("reset frame_len", frame_len, 0);
      check("reset err_code", err_code, 0);
      check("reset busy", busy, 0);
      rst_n = 1'b1;
      step();

      for (int t = 0; t < 4; t++) run_vec(t);

      // Length above MAX_WORDS on the small instance.
      for (int k = 0; k < 2; k++) begin
         n = (k == 0) ? 8'hFF : 8'h05;
         send_seq({96'h0, 24'hABCDEF, 8'hAB}, 4);
         send_byte(n);
         check($sformatf("maxw n=%0h stat_valid", n), stat_valid4, 1);
         check($sformatf("maxw n=%0h err_code", n), err_code4, 3);
         check($sformatf("maxw n=%0h frame_len", n), frame_len4, n);
         check($sformatf("maxw n=%0h pay_valid", n), pay_valid4, 0);
         check($sformatf("maxw n=%0h main busy", n), busy, 1);
         step();
         check($sformatf("maxw n=%0h stat_valid off", n), stat_valid4, 0);
         en = 1'b0; step(); en = 1'b1;
      end

      // Idle timeout after two payload bytes, then a clean frame.
      pay_q.delete();
      send_seq(128'hABCDEFAB011122, 7);
      repeat (15) step();
      check("timeout not early", stat_valid, 0);
      step();
      check("timeout stat_valid", stat_valid, 1);
      check("timeout err_code", err_code, 2);
      check("timeout frame_len", frame_len, 1);
      check("timeout payload kept", pay_q.size(), 2);
      run_vec(0);

      // Byte accepted in the cycle the idle count would expire.
      send_seq(128'hABCDEFAB01, 5);
      repeat (15) step();
      send_byte(8'h11);
      check("timeout race no status", stat_valid, 0);
      check("timeout race busy", busy, 1);
      send_seq(128'h22334445, 4);
      check("timeout race stat_valid", stat_valid, 1);
      check("timeout race err_code", err_code, 0);
      step();

      // Held status back-pressures the source.
      stat_ready = 1'b0;
      send_seq(tbl[1].data, tbl[1].nb);
      in_data = 8'hAB; in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         check($sformatf("hold c%0d in_ready", c), in_ready, 0);
         check($sformatf("hold c%0d stat_valid", c), stat_valid, 1);
         check($sformatf("hold c%0d err_code", c), err_code, 1);
         check($sformatf("hold c%0d frame_len", c), frame_len, 1);
         step();
      end
      in_valid = 1'b0;
      stat_ready = 1'b1;
      step();
      check("hold released stat_valid", stat_valid, 0);
      check("hold released busy", busy, 0);
      run_vec(0);

      // en low mid-payload aborts without status.
      send_seq(128'hABCDEFAB0111, 6);
      check("abort pre busy", busy, 1);
      en = 1'b0;
      step();
      check("abort busy", busy, 0);
      check("abort stat_valid", stat_valid, 0);
      check("abort pay_valid", pay_valid, 0);
      en = 1'b1;
      run_vec(2);

      // Asynchronous reset mid-frame.
      send_seq(128'hABCDEFAB0111, 6);
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst in_ready", in_ready, 1);
      check("async rst pay_valid", pay_valid, 0);
      check("async rst pay_data", pay_data, 0);
      check("async rst stat_valid", stat_valid, 0);
      check("async rst frame_len", frame_len, 0);
      check("async rst err_code", err_code, 0);
      check("async rst busy", busy, 0);
      step();
      rst_n = 1'b1;
      step();

      // Randomized frames against a frame-level reference.
      rnd_ready = 1'b1;
      for (int f = 0; f < 40; f++) begin
         fb.delete(); ep.delete();
         repeat ($urandom_range(0, 3)) begin
            bt = 8'($urandom_range(0, 255));
            if (bt == 8'hAB) bt = 8'h5A;
            fb.push_back(bt);
         end
         fb.push_back(8'hAB); fb.push_back(8'hCD); fb.push_back(8'hEF); fb.push_back(8'hAB);
         n = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 4));
         fb.push_back(n);
         if (n == 8'h00) begin
            ee = 2'd3;
         end else begin
            acc = n;
            for (int i = 0; i < 4 * int'(n); i++) begin
               bt = 8'($urandom_range(0, 255));
               fb.push_back(bt);
               ep.push_back(bt);
               acc = acc ^ bt;
            end
            if ($urandom_range(0, 3) == 0) begin
               csum = acc ^ 8'($urandom_range(1, 255));
               ee = 2'd1;
            end else begin
               csum = acc;
               ee = 2'd0;
            end
            fb.push_back(csum);
         end
         pay_q.delete(); st_len_q.delete(); st_err_q.delete();
         foreach (fb[i]) begin
            repeat ($urandom_range(0, 3)) step();
            send_byte(fb[i]);
         end
         g = 0;
         while (st_len_q.size() == 0 && g < 100) begin
            step();
            g++;
         end
         check($sformatf("rnd%0d status count", f), st_len_q.size(), 1);
         if (st_len_q.size() > 0) begin
            check($sformatf("rnd%0d frame_len", f), st_len_q[0], n);
            check($sformatf("rnd%0d err_code", f), st_err_q[0], ee);
         end
         check($sformatf("rnd%0d payload count", f), pay_q.size(), ep.size());
         for (int i = 0; i < ep.size() && i < pay_q.size(); i++)
            check($sformatf("rnd%0d payload[%0d]", f, i), pay_q[i], ep[i]);
         step();
      end
      rnd_ready = 1'b0;
      step();
      stat_ready = 1'b1;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
